// File: rtl/gate_op_sequencer_if.sv
// Request channel of the gate op sequencer: one command per valid&ready handshake.
interface gate_op_sequencer_if #(
   parameter int unsigned DATA_W = 8
);
   logic              valid;
   logic              ready;
   logic [2:0]        op;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;

   modport master (output valid, output op, output a, output b, input ready);
   modport slave  (input valid, input op, input a, input b, output ready);
endinterface

// File: rtl/gate_op_sequencer.sv
// Shares one 1-bit GATES unit between two requesters: round-robin arbitration,
// LSB-first bit-serial evaluation, result reassembly and a held response.
module gate_op_sequencer #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   gate_op_sequencer_if.slave req0,
   gate_op_sequencer_if.slave req1,
   output logic              gate_en,
   output logic [2:0]        gate_op,
   output logic              gate_d1,
   output logic              gate_d2,
   input  logic              gate_out,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_id,
   output logic              rsp_err,
   output logic              busy
);

   localparam int unsigned IDX_W = $clog2(DATA_W);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [2:0]        op_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] res;
   logic              id_q;
   logic              err_q;
   logic              last_grant;
   logic [IDX_W-1:0]  idx;

   logic              sel1;
   logic              accept;
   logic [2:0]        op_in;
   logic [DATA_W-1:0] a_in;
   logic [DATA_W-1:0] b_in;

   assign gate_op = op_q;
   assign busy    = (state != IDLE);

   // Next-state, arbitration and all combinational outputs.
   always_comb begin
      state_next = state;
      sel1       = 1'b0;
      accept     = 1'b0;
      op_in      = req0.op;
      a_in       = req0.a;
      b_in       = req0.b;
      req0.ready = 1'b0;
      req1.ready = 1'b0;
      gate_en    = 1'b0;
      gate_d1    = 1'b0;
      gate_d2    = 1'b0;
      rsp_valid  = 1'b0;
      rsp_data   = '0;
      rsp_id     = 1'b0;
      rsp_err    = 1'b0;
      case (state)
         IDLE: begin
            // On a tie the requester that did not win last time is granted.
            sel1       = req1.valid & (~req0.valid | ~last_grant);
            req1.ready = sel1;
            req0.ready = req0.valid & ~sel1;
            accept     = req0.valid | req1.valid;
            if (sel1) begin
               op_in = req1.op;
               a_in  = req1.a;
               b_in  = req1.b;
            end
            if (accept) begin
               state_next = (op_in[2] & op_in[1]) ? RESP : RUN;
            end
         end
         RUN: begin
            gate_en = 1'b1;
            gate_d1 = a_q[idx];
            gate_d2 = b_q[idx];
            if (idx == IDX_LAST) begin
               state_next = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_data  = res;
            rsp_id    = id_q;
            rsp_err   = err_q;
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Command latch on handshake and bit-serial result capture during RUN.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         res        <= '0;
         id_q       <= 1'b0;
         err_q      <= 1'b0;
         idx        <= '0;
         last_grant <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q       <= op_in;
                  a_q        <= a_in;
                  b_q        <= b_in;
                  id_q       <= sel1;
                  last_grant <= sel1;
                  err_q      <= op_in[2] & op_in[1];
                  idx        <= '0;
                  res        <= '0;
               end
            end
            RUN: begin
               res[idx] <= gate_out;
               idx      <= idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_op_sequencer.sv
// Scoreboard bench for gate_op_sequencer with a behavioural GATES unit as partner.
module tb_gate_op_sequencer;

   localparam int unsigned DATA_W = 8;

   typedef struct packed {
      logic       id;
      logic       err;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       gate_en, gate_d1, gate_d2, gate_out;
   logic [2:0] gate_op;
   logic       rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
   logic [7:0] rsp_data;

   gate_op_sequencer_if #(.DATA_W(DATA_W)) req0_bus ();
   gate_op_sequencer_if #(.DATA_W(DATA_W)) req1_bus ();

   gate_op_sequencer #(.DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req0      (req0_bus),
      .req1      (req1_bus),
      .gate_en   (gate_en),
      .gate_op   (gate_op),
      .gate_d1   (gate_d1),
      .gate_d2   (gate_d2),
      .gate_out  (gate_out),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Behavioural 1-bit GATES unit, combinational.
   always_comb begin
      gate_out = 1'b0;
      if (gate_en) begin
         case (gate_op)
            3'b000:  gate_out = gate_d1 & gate_d2;
            3'b001:  gate_out = gate_d1 | gate_d2;
            3'b010:  gate_out = ~gate_d1;
            3'b011:  gate_out = ~(gate_d1 & gate_d2);
            3'b100:  gate_out = ~(gate_d1 | gate_d2);
            3'b101:  gate_out = gate_d1 ^ gate_d2;
            default: gate_out = 1'b0;
         endcase
      end
   end

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];
   int   gq[$];
   int   cyc = 0;
   int   acc_cyc = 0;
   int   lat = 0;
   int   en_cnt = 0;
   int   rdy0_cnt = 0;
   int   rsp_cnt = 0;
   bit   both_seen = 0;
   bit   rsp_v_prev = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return ~a;
         3'b011:  return ~(a & b);
         3'b100:  return ~(a | b);
         3'b101:  return a ^ b;
         default: return 8'h00;
      endcase
   endfunction

   function automatic exp_t make_exp(input logic id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      e.id   = id;
      e.err  = (op >= 3'd6);
      e.data = e.err ? 8'h00 : model(op, a, b);
      return e;
   endfunction

   always @(posedge clk) cyc++;

   // Monitor: pushes expectations at request handshakes, pops at response handshakes.
   always @(negedge clk) begin
      if (rst) begin
         rsp_v_prev = 0;
      end else begin
         if (gate_en) en_cnt++;
         if (req0_bus.ready) rdy0_cnt++;
         if (req0_bus.ready && req1_bus.ready) both_seen = 1;
         if (rsp_valid && !rsp_v_prev) lat = cyc - acc_cyc;
         rsp_v_prev = rsp_valid;
         if (rsp_valid && rsp_ready) begin
            rsp_cnt++;
            check("rsp_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               check("rsp_data", rsp_data, e.data);
               check("rsp_id", rsp_id, e.id);
               check("rsp_err", rsp_err, e.err);
            end
         end
         if (req0_bus.valid && req0_bus.ready) begin
            sb.push_back(make_exp(1'b0, req0_bus.op, req0_bus.a, req0_bus.b));
            gq.push_back(0);
            acc_cyc = cyc;
         end
         if (req1_bus.valid && req1_bus.ready) begin
            sb.push_back(make_exp(1'b1, req1_bus.op, req1_bus.a, req1_bus.b));
            gq.push_back(1);
            acc_cyc = cyc;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input bit id, input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      if (id) begin
         req1_bus.valid = v; req1_bus.op = op; req1_bus.a = a; req1_bus.b = b;
      end else begin
         req0_bus.valid = v; req0_bus.op = op; req0_bus.a = a; req0_bus.b = b;
      end
   endtask

   task automatic issue(input bit id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      bit got;
      got = 0;
      set_req(id, 1'b1, op, a, b);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if ((id ? req1_bus.ready : req0_bus.ready) == 1'b1) begin
            got = 1;
            break;
         end
      end
      check("accept_timeout", 32'(got), 1);
      tick();
      set_req(id, 1'b0, op, a, b);
   endtask

   task automatic drain();
      bit ok;
      ok = 0;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (sb.size() == 0 && !busy) begin
            ok = 1;
            break;
         end
      end
      check("drain_timeout", 32'(ok), 1);
   endtask

   task automatic wait_grants(input int n);
      bit ok;
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (gq.size() >= n) begin
            ok = 1;
            break;
         end
      end
      check("grant_timeout", 32'(ok), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit         stable, rdy_seen, v_seen, ok;
      logic [7:0] d_hold;
      logic       id_hold, err_hold;
      int         k, rc;

      rst = 1'b1;
      rsp_ready = 1'b1;
      set_req(0, 1'b0, 3'd0, 8'h00, 8'h00);
      set_req(1, 1'b0, 3'd0, 8'h00, 8'h00);
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // 1: reset state, then AND from req0
      check("rst_busy", busy, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_gate_en", gate_en, 0);
      check("rst_gate_op", gate_op, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_req0_ready", req0_bus.ready, 0);
      en_cnt = 0;
      rdy0_cnt = 0;
      issue(0, 3'b000, 8'hF0, 8'hCC);
      drain();
      check("t1_latency", lat, 9);
      check("t1_gate_en_cycles", en_cnt, 8);
      check("t1_req0_ready_cycles", rdy0_cnt, 1);

      // 2: op sweep from req1
      for (int op = 1; op <= 5; op++) begin
         issue(1, 3'(op), 8'hA5, 8'h3C);
         drain();
      end

      // 3: continuous tie, alternation
      gq.delete();
      set_req(0, 1'b1, 3'b101, 8'h0F, 8'hFF);
      set_req(1, 1'b1, 3'b101, 8'h33, 8'h55);
      wait_grants(4);
      set_req(0, 1'b0, 3'b101, 8'h0F, 8'hFF);
      set_req(1, 1'b0, 3'b101, 8'h33, 8'h55);
      drain();
      check("t3_grant_count", gq.size(), 4);
      for (int i = 0; i < 4 && i < gq.size(); i++) begin
         check("t3_grant_order", gq[i], i % 2);
      end

      // 4: illegal op
      en_cnt = 0;
      issue(0, 3'b110, 8'hFF, 8'hFF);
      drain();
      check("t4_latency", lat, 1);
      check("t4_gate_en_cycles", en_cnt, 0);

      // 5: backpressure with a pending request
      rsp_ready = 1'b0;
      issue(0, 3'b001, 8'h12, 8'h34);
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            ok = 1;
            break;
         end
      end
      check("t5_rsp_timeout", 32'(ok), 1);
      d_hold = rsp_data;
      id_hold = rsp_id;
      err_hold = rsp_err;
      set_req(1, 1'b1, 3'b101, 8'hC3, 8'h0F);
      stable = 1;
      rdy_seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_data !== d_hold || rsp_id !== id_hold ||
             rsp_err !== err_hold || busy !== 1'b1) stable = 0;
         if (req0_bus.ready || req1_bus.ready) rdy_seen = 1;
      end
      check("t5_stable", 32'(stable), 1);
      check("t5_ready_in_stall", 32'(rdy_seen), 0);
      tick();
      rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("t5_pending_accept", req1_bus.ready, 1);
      tick();
      set_req(1, 1'b0, 3'b101, 8'hC3, 8'h0F);
      drain();

      // 6: reset in the middle of RUN
      issue(0, 3'b000, 8'hFF, 8'hFF);
      k = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (gate_en) k++;
         if (k == 5) break;
      end
      check("t6_reach_idx4", k, 5);
      rst = 1'b1;
      sb.delete();
      tick();
      check("t6_gate_en", gate_en, 0);
      check("t6_gate_op", gate_op, 0);
      check("t6_gate_d", {gate_d1, gate_d2}, 0);
      check("t6_rsp_valid", rsp_valid, 0);
      check("t6_rsp_data", rsp_data, 0);
      check("t6_rsp_id_err", {rsp_id, rsp_err}, 0);
      check("t6_busy", busy, 0);
      rst = 1'b0;
      rc = rsp_cnt;
      v_seen = 0;
      repeat (15) begin
         tick();
         if (rsp_valid) v_seen = 1;
      end
      check("t6_no_rsp_valid", 32'(v_seen), 0);
      check("t6_no_rsp_count", rsp_cnt - rc, 0);
      gq.delete();
      set_req(0, 1'b1, 3'b001, 8'h81, 8'h18);
      set_req(1, 1'b1, 3'b011, 8'h7E, 8'hE7);
      wait_grants(1);
      set_req(0, 1'b0, 3'b001, 8'h81, 8'h18);
      set_req(1, 1'b0, 3'b011, 8'h7E, 8'hE7);
      drain();
      check("t6_tie_after_rst", (gq.size() > 0) ? gq[0] : -1, 0);

      check("never_both_ready", 32'(both_seen), 0);
      check("sb_empty_end", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
